// File: rtl/des_pkg.sv
// des_pkg: scan-code constants, entry FSM encoding and digit-count type for the PS/2 hex loader
package des_pkg;
    localparam int CNT_W = 5;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_FULL = 5'd16;
    typedef enum logic [1:0] {MSG_ENTRY, KEY_ENTRY, DONE} state_t;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_ESC   = 8'h76;
    // {is_hex, nibble} for a make code; non-hex codes return all zeros
    function automatic logic [4:0] hex_decode(input logic [7:0] code);
        case (code)
            8'h45: return 5'h10;
            8'h16: return 5'h11;
            8'h1E: return 5'h12;
            8'h26: return 5'h13;
            8'h25: return 5'h14;
            8'h2E: return 5'h15;
            8'h36: return 5'h16;
            8'h3D: return 5'h17;
            8'h3E: return 5'h18;
            8'h46: return 5'h19;
            8'h1C: return 5'h1A;
            8'h32: return 5'h1B;
            8'h21: return 5'h1C;
            8'h23: return 5'h1D;
            8'h24: return 5'h1E;
            8'h2B: return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction
endpackage

// File: rtl/ps2_hex_loader_if.sv
// ps2_hex_loader_if: PS/2 lines in, assembled words/counts/status out
//   master: keyboard side (drives keyclk/keydata, observes results)
//   slave:  loader side (samples keyclk/keydata, drives results)
interface ps2_hex_loader_if;
    import des_pkg::*;
    logic keyclk;
    logic keydata;
    logic [63:0] usermessage;
    logic [63:0] usercipher;
    cnt_t char_count_1;
    cnt_t char_count_2;
    logic refresh;
    logic inputComplete;
    modport master (output keyclk, keydata, input usermessage, usercipher, char_count_1, char_count_2, refresh, inputComplete);
    modport slave (input keyclk, keydata, output usermessage, usercipher, char_count_1, char_count_2, refresh, inputComplete);
endinterface

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 frame receiver, one byte_valid pulse per clean 11-bit frame
//   keyclk/keydata: raw asynchronous PS/2 lines
//   byte_out/byte_valid: received data byte and its one-cycle strobe
module ps2_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       keyclk,
    input  logic       keydata,
    output logic [7:0] byte_out,
    output logic       byte_valid
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
    logic [1:0] kc_s, kd_s;
    logic kc_prev;
    logic [3:0] cnt;
    logic [9:0] shr;
    logic [TW-1:0] tmo;
    logic fall;
    assign fall = kc_prev && !kc_s[1];
    // shr collects start, d0..d7, parity LSB-first; the stop bit is checked live
    always_ff @(posedge clk) begin
        if (rst) begin
            kc_s <= 2'b11;
            kd_s <= 2'b11;
            kc_prev <= 1'b1;
            cnt <= '0;
            shr <= '0;
            tmo <= '0;
            byte_out <= '0;
            byte_valid <= 1'b0;
        end else begin
            kc_s <= {kc_s[0], keyclk};
            kd_s <= {kd_s[0], keydata};
            kc_prev <= kc_s[1];
            byte_valid <= 1'b0;
            if (fall) begin
                tmo <= '0;
                if (cnt == 4'd10) begin
                    cnt <= '0;
                    if (!shr[0] && kd_s[1] && ^shr[9:1]) begin
                        byte_out <= shr[8:1];
                        byte_valid <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                    shr <= {kd_s[1], shr[9:1]};
                end
            end else if (cnt != '0) begin
                tmo <= (tmo == TMAX) ? '0 : tmo + 1'b1;
                if (tmo == TMAX) cnt <= '0;
            end else begin
                tmo <= '0;
            end
        end
    end
endmodule

// File: rtl/ps2_hex_loader.sv
// ps2_hex_loader: types a 16-digit plaintext then a 16-digit DES key over PS/2
//   clk/rst: system clock, synchronous active-high reset
//   bus (slave): keyclk/keydata in; usermessage, usercipher, char_count_1/2, refresh, inputComplete out
module ps2_hex_loader import des_pkg::*; #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input logic clk,
    input logic rst,
    ps2_hex_loader_if.slave bus
);
    logic [7:0] rx_byte;
    logic rx_valid;
    state_t state;
    logic skip, refresh, done;
    logic [63:0] msg, key, word, nw;
    cnt_t c1, c2, cnt, nc;
    logic is_hex, key_mode, go, dig_ok, bks_ok, edit, adv, esc;
    logic [3:0] nib;
    ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk(clk),
        .rst(rst),
        .keyclk(bus.keyclk),
        .keydata(bus.keydata),
        .byte_out(rx_byte),
        .byte_valid(rx_valid)
    );
    // a byte following F0 or E0 is swallowed; prefixes themselves never act
    always_comb begin
        {is_hex, nib} = hex_decode(rx_byte);
        go = rx_valid && !skip && rx_byte != SC_BREAK && rx_byte != SC_EXT;
        key_mode = state == KEY_ENTRY;
        word = key_mode ? key : msg;
        cnt = key_mode ? c2 : c1;
        dig_ok = is_hex && cnt != CNT_FULL;
        bks_ok = rx_byte == SC_BKSP && cnt != '0;
        edit = go && state != DONE && (dig_ok || bks_ok);
        adv = go && state != DONE && rx_byte == SC_ENTER && cnt == CNT_FULL;
        esc = go && rx_byte == SC_ESC;
        nw = dig_ok ? {word[59:0], nib} : {4'h0, word[63:4]};
        nc = dig_ok ? cnt + 1'b1 : cnt - 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MSG_ENTRY;
            skip <= 1'b0;
            msg <= '0;
            key <= '0;
            c1 <= '0;
            c2 <= '0;
            refresh <= 1'b0;
            done <= 1'b0;
        end else begin
            refresh <= edit || esc;
            if (rx_valid) skip <= !skip && (rx_byte == SC_BREAK || rx_byte == SC_EXT);
            if (esc) begin
                state <= MSG_ENTRY;
                msg <= '0;
                key <= '0;
                c1 <= '0;
                c2 <= '0;
                done <= 1'b0;
            end else if (edit && key_mode) begin
                key <= nw;
                c2 <= nc;
            end else if (edit) begin
                msg <= nw;
                c1 <= nc;
            end else if (adv) begin
                state <= key_mode ? DONE : KEY_ENTRY;
                done <= key_mode;
            end
        end
    end
    assign bus.usermessage = msg;
    assign bus.usercipher = key;
    assign bus.char_count_1 = c1;
    assign bus.char_count_2 = c2;
    assign bus.refresh = refresh;
    assign bus.inputComplete = done;
endmodule

// File: tb/tb_ps2_hex_loader.sv
// tb_ps2_hex_loader: PS/2 keystroke stimulus against a behavioural entry model with a refresh-driven scoreboard
module tb_ps2_hex_loader;
    localparam int TMO = 200;
    typedef struct packed {
        logic [63:0] m;
        logic [63:0] k;
        logic [4:0]  c1;
        logic [4:0]  c2;
        logic        done;
    } snap_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    ps2_hex_loader_if bus();
    ps2_hex_loader #(.TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));
    int tests = 0;
    int fails = 0;
    int refreshes = 0;
    snap_t q[$];
    logic [63:0] m_msg = '0;
    logic [63:0] m_key = '0;
    int m_c1 = 0;
    int m_c2 = 0;
    int m_st = 0;
    bit m_skip = 0;
    logic [7:0] dig_codes [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                   8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
    function automatic snap_t dut_snap();
        return {bus.usermessage, bus.usercipher, bus.char_count_1, bus.char_count_2, bus.inputComplete};
    endfunction
    function automatic snap_t model_snap();
        return {m_msg, m_key, 5'(m_c1), 5'(m_c2), m_st == 2};
    endfunction
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic chk_snap(input string name, input snap_t act, input snap_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got m=%h k=%h c1=%0d c2=%0d done=%b expected m=%h k=%h c1=%0d c2=%0d done=%b",
                     name, act.m, act.k, act.c1, act.c2, act.done, exp.m, exp.k, exp.c1, exp.c2, exp.done);
        end
    endtask
    // reference model: key semantics as arithmetic on a digit string value
    task automatic model_key(input logic [7:0] b);
        int d;
        int c;
        bit ch;
        logic [63:0] w;
        d = -1;
        ch = 0;
        if (m_skip) begin
            m_skip = 0;
            return;
        end
        if (b == 8'hF0 || b == 8'hE0) begin
            m_skip = 1;
            return;
        end
        for (int i = 0; i < 16; i++) if (dig_codes[i] == b) d = i;
        w = (m_st == 1) ? m_key : m_msg;
        c = (m_st == 1) ? m_c2 : m_c1;
        if (b == 8'h76) begin
            m_msg = '0;
            m_key = '0;
            m_c1 = 0;
            m_c2 = 0;
            m_st = 0;
            q.push_back(model_snap());
            return;
        end
        if (m_st == 2) return;
        if (d >= 0 && c < 16) begin
            w = w * 16 + 64'(d);
            c++;
            ch = 1;
        end else if (b == 8'h66 && c > 0) begin
            w = w / 16;
            c--;
            ch = 1;
        end else if (b == 8'h5A && c == 16) begin
            m_st++;
        end
        if (ch && m_st == 1) begin
            m_key = w;
            m_c2 = c;
        end else if (ch) begin
            m_msg = w;
            m_c1 = c;
        end
        if (ch) q.push_back(model_snap());
    endtask
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.keydata = f[i];
            idle(5);
            bus.keyclk = 1'b0;
            idle(5);
            bus.keyclk = 1'b1;
            idle(5);
        end
        bus.keydata = 1'b1;
    endtask
    task automatic press(input logic [7:0] b);
        model_key(b);
        send_frame(b, 1'b0, 11);
        idle(15);
        chk_snap("settle", dut_snap(), model_snap());
    endtask
    task automatic press_digits(input logic [63:0] v);
        for (int i = 15; i >= 0; i--) press(dig_codes[v[i*4 +: 4]]);
    endtask
    // monitor: every refresh pulse must match the next expected snapshot
    always @(negedge clk) begin
        snap_t e;
        if (!rst && bus.refresh) begin
            refreshes++;
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL refresh_unexpected: got refresh=1 expected refresh=0 (m=%h c1=%0d)", bus.usermessage, bus.char_count_1);
            end else begin
                e = q.pop_front();
                chk_snap("refresh_snap", dut_snap(), e);
            end
        end
    end
    initial begin
        int r0;
        logic [7:0] b;
        bus.keyclk = 1'b1;
        bus.keydata = 1'b1;
        idle(4);
        rst = 1'b0;
        idle(2);
        chk_snap("reset_state", dut_snap(), 139'd0);
        chk("reset_refresh", 64'(bus.refresh), 64'd0);
        r0 = refreshes;
        press_digits(64'h0123456789ABCDEF);
        press(8'h5A);
        chk("msg_full", bus.usermessage, 64'h0123456789ABCDEF);
        chk("count1_full", 64'(bus.char_count_1), 64'd16);
        chk("not_done_after_msg", 64'(bus.inputComplete), 64'd0);
        chk("msg_refreshes", 64'(refreshes - r0), 64'd16);
        r0 = refreshes;
        press_digits(64'h133457799BBCDFF1);
        press(8'h5A);
        chk("key_full", bus.usercipher, 64'h133457799BBCDFF1);
        chk("done_high", 64'(bus.inputComplete), 64'd1);
        chk("key_refreshes", 64'(refreshes - r0), 64'd16);
        press(8'h2E);
        press(8'h66);
        chk("done_ignores_keys", bus.usercipher, 64'h133457799BBCDFF1);
        r0 = refreshes;
        press(8'h76);
        chk("esc_refresh", 64'(refreshes - r0), 64'd1);
        chk("esc_done_low", 64'(bus.inputComplete), 64'd0);
        chk("esc_msg_zero", bus.usermessage, 64'd0);
        press(8'h16);
        press(8'h1E);
        press(8'h26);
        press(8'h66);
        chk("bksp_msg", bus.usermessage, 64'h12);
        chk("bksp_count", 64'(bus.char_count_1), 64'd2);
        press(8'h5A);
        press(8'h25);
        chk("enter_short_ignored", bus.usermessage, 64'h124);
        r0 = refreshes;
        press(8'hF0);
        press(8'h16);
        press(8'hE0);
        press(8'h1E);
        chk("break_no_change", 64'(refreshes - r0), 64'd0);
        chk("break_msg", bus.usermessage, 64'h124);
        send_frame(8'h3D, 1'b1, 11);
        idle(20);
        chk("bad_parity_ignored", bus.usermessage, 64'h124);
        send_frame(8'h3E, 1'b0, 5);
        idle(TMO + 50);
        press(8'h46);
        chk("after_timeout", bus.usermessage, 64'h1249);
        chk("after_timeout_cnt", 64'(bus.char_count_1), 64'd4);
        for (int n = 0; n < 150; n++) begin
            r0 = int'($urandom_range(0, 99));
            b = (r0 < 62) ? dig_codes[$urandom_range(0, 15)] :
                (r0 < 72) ? 8'h66 : (r0 < 82) ? 8'h5A : (r0 < 85) ? 8'h76 :
                (r0 < 89) ? 8'hF0 : (r0 < 92) ? 8'hE0 : 8'h1A;
            press(b);
        end
        press(8'h76);
        for (int i = 1; i <= 8; i++) press(dig_codes[i]);
        chk("pre_reset_count", 64'(bus.char_count_1), 64'd8);
        chk("queue_drained", 64'(q.size()), 64'd0);
        send_frame(8'h16, 1'b0, 5);
        rst = 1'b1;
        @(negedge clk);
        chk_snap("rst_midframe", dut_snap(), 139'd0);
        chk("rst_refresh", 64'(bus.refresh), 64'd0);
        rst = 1'b0;
        m_msg = '0;
        m_key = '0;
        m_c1 = 0;
        m_c2 = 0;
        m_st = 0;
        m_skip = 0;
        idle(5);
        press(8'h1C);
        chk("post_reset_digit", bus.usermessage, 64'hA);
        idle(5);
        chk("queue_empty_end", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
